// File: rtl/mem_arbiter_if.sv
// ----------------------------------------------------------------------------
// mem_arbiter_if
//
// External memory bus shared through mem_arbiter (MAR/MDR with MFC handshake).
//
// Signals:
//   memEN      memory enable, held for the whole access
//   RW         1 = read, 0 = write
//   mem_addr   address presented to MAR
//   mem_wdata  data presented to MDR for writes
//   mem_rdata  data returned by memory for reads
//   MFC        memory function complete
//
// Modports:
//   master  arbiter side (drives enable/RW/address/data, receives rdata/MFC)
//   slave   memory side
// ----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int unsigned AW = 16,
    parameter int unsigned DW = 16
);

    logic          memEN;
    logic          RW;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          MFC;

    modport master (
        output memEN,
        output RW,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  MFC
    );

    modport slave (
        input  memEN,
        input  RW,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output MFC
    );

endinterface

// File: rtl/mem_arbiter.sv
// ----------------------------------------------------------------------------
// mem_arbiter
//
// Shares one external memory between the instruction-fetch path (port 0) and
// the load/store FSM (port 1). One requester's command is latched, driven onto
// the memory bus until MFC arrives (or a timeout expires), and completion is
// reported with a one-cycle done pulse (plus err on timeout). When both ports
// request in the same cycle the port that was not granted last wins, so
// neither side can starve the other.
//
// Parameters:
//   AW       address width
//   DW       data width
//   TIMEOUT  max cycles memEN stays high waiting for MFC; 0 disables timeout
//
// Ports:
//   clk            system clock, all state on rising edge
//   rst            asynchronous active-low reset
//   req0/req1      port request, held until that port's done
//   rw0/rw1        1 = read, 0 = write
//   addr0/addr1    port address
//   wdata0/wdata1  port write data
//   done0/done1    one-cycle completion pulse
//   err0/err1      one-cycle timeout pulse, coincident with done
//   rdata          read data, updated only by a successful read
//   busy           high while a transaction is in BUSY or DONE
//   owner          port currently / last granted
//   mem            memory bus (master side)
// ----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned AW      = 16,
    parameter int unsigned DW      = 16,
    parameter int unsigned TIMEOUT = 15
) (
    input  logic          clk,
    input  logic          rst,

    input  logic          req0,
    input  logic          rw0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          done0,
    output logic          err0,

    input  logic          req1,
    input  logic          rw1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          done1,
    output logic          err1,

    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          owner,

    mem_arbiter_if.master mem
);

    // Counter only has to reach TIMEOUT-1.
    localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } state_e;

    state_e        state_q;
    logic          last_grant_q;
    logic [CW-1:0] tcnt_q;

    // Arbitration decision for the current IDLE cycle.
    logic          grant;
    logic          grant_rw;
    logic [AW-1:0] grant_addr;
    logic [DW-1:0] grant_wdata;

    always_comb begin
        // Contest goes to the port opposite the last grant; otherwise the
        // only requester wins (req1 alone selects port 1, req0 alone port 0).
        if (req0 && req1) begin
            grant = ~last_grant_q;
        end else begin
            grant = req1;
        end
        grant_rw    = grant ? rw1    : rw0;
        grant_addr  = grant ? addr1  : addr0;
        grant_wdata = grant ? wdata1 : wdata0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            last_grant_q  <= 1'b1;
            tcnt_q        <= '0;
            mem.memEN     <= 1'b0;
            mem.RW        <= 1'b1;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            rdata         <= '0;
            done0         <= 1'b0;
            done1         <= 1'b0;
            err0          <= 1'b0;
            err1          <= 1'b0;
            busy          <= 1'b0;
            owner         <= 1'b0;
        end else begin
            // Completion flags are pulses: only the BUSY exit sets them.
            done0 <= 1'b0;
            done1 <= 1'b0;
            err0  <= 1'b0;
            err1  <= 1'b0;

            case (state_q)
                StIdle: begin
                    // A still-high MFC belongs to the previous access; wait
                    // for the memory to release it before issuing.
                    if (!mem.MFC && (req0 || req1)) begin
                        mem.RW        <= grant_rw;
                        mem.mem_addr  <= grant_addr;
                        mem.mem_wdata <= grant_wdata;
                        mem.memEN     <= 1'b1;
                        owner         <= grant;
                        last_grant_q  <= grant;
                        tcnt_q        <= '0;
                        busy          <= 1'b1;
                        state_q       <= StBusy;
                    end
                end

                StBusy: begin
                    // Requests are not re-sampled here: a port dropping req
                    // early still gets its done pulse.
                    if (mem.MFC) begin
                        if (mem.RW) begin
                            rdata <= mem.mem_rdata;
                        end
                        if (owner) begin
                            done1 <= 1'b1;
                        end else begin
                            done0 <= 1'b1;
                        end
                        mem.memEN <= 1'b0;
                        state_q   <= StDone;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TO_LAST)) begin
                        // MFC wins over timeout on the same edge.
                        if (owner) begin
                            done1 <= 1'b1;
                            err1  <= 1'b1;
                        end else begin
                            done0 <= 1'b1;
                            err0  <= 1'b1;
                        end
                        mem.memEN <= 1'b0;
                        state_q   <= StDone;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end

                StDone: begin
                    // Requests ignored: the requester drops req on this edge.
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end

                default: begin
                    mem.memEN <= 1'b0;
                    busy      <= 1'b0;
                    state_q   <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int unsigned AW      = 16;
    localparam int unsigned DW      = 16;
    localparam int unsigned TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 1'b0, req1 = 1'b0, rw0 = 1'b1, rw1 = 1'b1;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          done0, done1, err0, err1, busy, owner;
    logic [DW-1:0] rdata;

    mem_arbiter_if #(.AW(AW), .DW(DW)) mbus ();

    mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .clk    (clk),
        .rst    (rst),
        .req0   (req0),
        .rw0    (rw0),
        .addr0  (addr0),
        .wdata0 (wdata0),
        .done0  (done0),
        .err0   (err0),
        .req1   (req1),
        .rw1    (rw1),
        .addr1  (addr1),
        .wdata1 (wdata1),
        .done1  (done1),
        .err1   (err1),
        .rdata  (rdata),
        .busy   (busy),
        .owner  (owner),
        .mem    (mbus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- memory environment ----------------
    // Per access delay in cycles from memEN rising to MFC being sampled;
    // 0 means the memory never answers.
    logic [DW-1:0] env_mem [256];
    int            delay_q [$];
    int            cur_delay = 1;
    int            mcnt      = 0;
    bit            mfc_stuck = 1'b0;

    initial begin
        mbus.MFC       = 1'b0;
        mbus.mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                mcnt     = 0;
                mbus.MFC = 1'b0;
            end else if (mbus.memEN) begin
                if (mcnt == 0) begin
                    cur_delay = (delay_q.size() > 0) ? delay_q.pop_front() : 1;
                end
                mcnt++;
                if (mcnt == cur_delay) begin
                    mbus.MFC = 1'b1;
                    if (mbus.RW) mbus.mem_rdata = env_mem[mbus.mem_addr[7:0]];
                    else         env_mem[mbus.mem_addr[7:0]] = mbus.mem_wdata;
                end
            end else begin
                mcnt = 0;
                if (!mfc_stuck) mbus.MFC = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- observation helper ----------------
    int            r_en;
    bit            r_got0, r_got1, r_err0, r_err1, r_to, r_busy;
    logic [DW-1:0] r_rdata;
    logic          snap_rw, snap_owner;
    logic [AW-1:0] snap_addr;
    logic [DW-1:0] snap_wdata;

    // Waits (bounded) for a done pulse; records the first bus command seen and
    // drops the finishing port's req on the sample where done is seen.
    task automatic run_until_done(input int maxc);
        bit seen_en;
        seen_en = 1'b0;
        r_en = 0; r_got0 = 0; r_got1 = 0; r_err0 = 0; r_err1 = 0; r_to = 1; r_busy = 0;
        for (int i = 0; i < maxc; i++) begin
            @(negedge clk);
            if (mbus.memEN) begin
                if (!seen_en) begin
                    snap_rw = mbus.RW; snap_addr = mbus.mem_addr;
                    snap_wdata = mbus.mem_wdata; snap_owner = owner;
                    seen_en = 1'b1;
                end
                r_en++;
            end
            if (done0 || done1) begin
                r_got0 = done0; r_got1 = done1; r_err0 = err0; r_err1 = err1;
                r_rdata = rdata; r_busy = busy; r_to = 0;
                if (done0) req0 = 1'b0;
                if (done1) req1 = 1'b0;
                break;
            end
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
        repeat (2) @(negedge clk);
        delay_q.delete();
        mfc_stuck = 1'b0;
        rst = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (mbus.memEN !== 1'b0) begin failures++; $display("FAIL reset_memEN got %b want 0", mbus.memEN); end
        checks++; if (mbus.RW !== 1'b1) begin failures++; $display("FAIL reset_RW got %b want 1", mbus.RW); end
        checks++; if (mbus.mem_addr !== 16'h0 || mbus.mem_wdata !== 16'h0) begin failures++;
            $display("FAIL reset_bus got addr=%h wdata=%h want 0/0", mbus.mem_addr, mbus.mem_wdata); end
        checks++; if (rdata !== 16'h0) begin failures++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if ({done0, done1, err0, err1, busy, owner} !== 6'b0) begin failures++;
            $display("FAIL reset_flags got %b want 000000", {done0, done1, err0, err1, busy, owner}); end
        rst = 1'b1;
    endtask

    task automatic test_single_read();
        env_mem[8'h42] = 16'hBEEF;
        delay_q.push_back(3);
        @(negedge clk);
        rw1 = 1'b1; addr1 = 16'h0042; req1 = 1'b1;
        run_until_done(60);
        checks++; if (r_to !== 1'b0) begin failures++; $display("FAIL rd_timeout got no done want done1"); end
        checks++; if (r_en !== 3) begin failures++; $display("FAIL rd_en_cycles got %0d want 3", r_en); end
        checks++; if (snap_rw !== 1'b1 || snap_addr !== 16'h0042) begin failures++;
            $display("FAIL rd_cmd got RW=%b addr=%h want 1/0042", snap_rw, snap_addr); end
        checks++; if ({r_got0, r_got1, r_err1} !== 3'b010) begin failures++;
            $display("FAIL rd_done got d0=%b d1=%b e1=%b want 0/1/0", r_got0, r_got1, r_err1); end
        checks++; if (r_rdata !== 16'hBEEF) begin failures++; $display("FAIL rd_rdata got %h want BEEF", r_rdata); end
        checks++; if (owner !== 1'b1) begin failures++; $display("FAIL rd_owner got %b want 1", owner); end
    endtask

    task automatic test_write();
        delay_q.push_back(2);
        rw0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h1234; req0 = 1'b1;
        run_until_done(60);
        checks++; if (r_to !== 1'b0 || r_got0 !== 1'b1 || r_err0 !== 1'b0) begin failures++;
            $display("FAIL wr_done got to=%b d0=%b e0=%b want 0/1/0", r_to, r_got0, r_err0); end
        checks++; if (snap_rw !== 1'b0 || snap_wdata !== 16'h1234 || snap_addr !== 16'h0010) begin failures++;
            $display("FAIL wr_cmd got RW=%b wdata=%h addr=%h want 0/1234/0010", snap_rw, snap_wdata, snap_addr); end
        checks++; if (r_rdata !== 16'hBEEF) begin failures++; $display("FAIL wr_rdata_kept got %h want BEEF", r_rdata); end
        checks++; if (env_mem[8'h10] !== 16'h1234) begin failures++;
            $display("FAIL wr_mem got %h want 1234", env_mem[8'h10]); end
    endtask

    task automatic test_contention();
        int exp_port [4];
        exp_port = '{0, 1, 0, 1};
        apply_reset();
        env_mem[8'h20] = 16'h2222; env_mem[8'h30] = 16'h3333;
        rw0 = 1'b1; addr0 = 16'h0020; rw1 = 1'b1; addr1 = 16'h0030;
        repeat (4) delay_q.push_back(1);
        for (int k = 0; k < 4; k++) begin
            if (k == 0 || k == 2) begin req0 = 1'b1; req1 = 1'b1; end
            run_until_done(60);
            checks++; if (r_to !== 1'b0 || r_got0 !== (exp_port[k] == 0) || r_got1 !== (exp_port[k] == 1)) begin
                failures++; $display("FAIL arb_order[%0d] got d0=%b d1=%b want port %0d", k, r_got0, r_got1, exp_port[k]); end
            checks++; if (r_en !== 1 || r_rdata !== ((exp_port[k] == 0) ? 16'h2222 : 16'h3333)) begin
                failures++; $display("FAIL arb_data[%0d] got en=%0d rdata=%h want 1/%h", k, r_en, r_rdata,
                                     (exp_port[k] == 0) ? 16'h2222 : 16'h3333); end
        end
    endtask

    task automatic test_timeout();
        delay_q.push_back(0);
        rw0 = 1'b1; addr0 = 16'h0020; req0 = 1'b1;
        run_until_done(80);
        checks++; if (r_en !== TIMEOUT) begin failures++; $display("FAIL to_en_cycles got %0d want %0d", r_en, TIMEOUT); end
        checks++; if (r_to !== 1'b0 || {r_got0, r_err0, r_got1, r_err1} !== 4'b1100) begin failures++;
            $display("FAIL to_flags got to=%b d0e0d1e1=%b want 0/1100", r_to, {r_got0, r_err0, r_got1, r_err1}); end
        checks++; if (r_rdata !== 16'h3333) begin failures++; $display("FAIL to_rdata_kept got %h want 3333", r_rdata); end
        @(negedge clk);
        checks++; if ({done0, err0, mbus.memEN} !== 3'b000) begin failures++;
            $display("FAIL to_pulse_len got done0/err0/memEN=%b want 000", {done0, err0, mbus.memEN}); end
        @(negedge clk);
        checks++; if (busy !== 1'b0 || mbus.memEN !== 1'b0) begin failures++;
            $display("FAIL to_idle got busy=%b memEN=%b want 0/0", busy, mbus.memEN); end
    endtask

    task automatic test_reset_mid_busy();
        int bad;
        delay_q.push_back(0);
        rw1 = 1'b1; addr1 = 16'h0030; req1 = 1'b1;
        repeat (4) @(negedge clk);
        checks++; if (mbus.memEN !== 1'b1 || busy !== 1'b1) begin failures++;
            $display("FAIL rmb_busy got memEN=%b busy=%b want 1/1", mbus.memEN, busy); end
        #2 rst = 1'b0; req1 = 1'b0;
        #1;
        checks++; if ({mbus.memEN, busy, done1, owner} !== 4'b0000 || rdata !== 16'h0) begin failures++;
            $display("FAIL rmb_async got memEN/busy/done1/owner=%b rdata=%h want 0000/0000",
                     {mbus.memEN, busy, done1, owner}, rdata); end
        rst = 1'b1;
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (done0 || done1 || mbus.memEN) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL rmb_no_done got %0d active cycles want 0", bad); end
    endtask

    task automatic test_mfc_stuck();
        int bad;
        delay_q.push_back(1);
        mfc_stuck = 1'b1;
        rw0 = 1'b1; addr0 = 16'h0020; req0 = 1'b1;
        run_until_done(60);
        checks++; if (r_got0 !== 1'b1 || r_rdata !== 16'h2222) begin failures++;
            $display("FAIL stuck_first got d0=%b rdata=%h want 1/2222", r_got0, r_rdata); end
        rw1 = 1'b1; addr1 = 16'h0030; req1 = 1'b1;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (mbus.memEN) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL stuck_blocked got %0d memEN cycles want 0", bad); end
        delay_q.push_back(2);
        @(posedge clk);
        mfc_stuck = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (mbus.memEN !== 1'b0) begin failures++; $display("FAIL stuck_release got memEN=%b want 0", mbus.memEN); end
        @(negedge clk);
        checks++; if (mbus.memEN !== 1'b1 || owner !== 1'b1 || mbus.mem_addr !== 16'h0030) begin failures++;
            $display("FAIL stuck_grant got memEN=%b owner=%b addr=%h want 1/1/0030", mbus.memEN, owner, mbus.mem_addr); end
        run_until_done(60);
        checks++; if (r_got1 !== 1'b1 || r_rdata !== 16'h3333) begin failures++;
            $display("FAIL stuck_second got d1=%b rdata=%h want 1/3333", r_got1, r_rdata); end
    endtask

    // Random traffic against a transaction-level model: service order from the
    // alternation rule, outcome from the per-access delay, data from a shadow
    // copy of memory.
    task automatic test_random();
        logic [DW-1:0] shadow [256];
        logic [DW-1:0] exp_rdata;
        logic          c_rw    [2];
        logic [AW-1:0] c_addr  [2];
        logic [DW-1:0] c_wdata [2];
        int            order [$];
        int            dly   [$];
        int            last, mask, p, d, exp_en;
        bit            ok;
        apply_reset();
        for (int i = 0; i < 256; i++) begin
            env_mem[i] = 16'(i * 16'h0101) ^ 16'h5A5A;
            shadow[i]  = 16'(i * 16'h0101) ^ 16'h5A5A;
        end
        last = 1; exp_rdata = '0;
        for (int rnd = 0; rnd < 40; rnd++) begin
            mask = $urandom_range(1, 3);
            order.delete(); dly.delete();
            if (mask == 3) begin
                order.push_back(1 - last); order.push_back(last);
            end else begin
                order.push_back(mask >> 1);
            end
            last = order[order.size() - 1];
            for (int k = 0; k < 2; k++) begin
                c_rw[k] = 1'($urandom_range(0, 1));
                c_addr[k] = 16'($urandom_range(0, 255));
                c_wdata[k] = 16'($urandom);
            end
            foreach (order[k]) begin
                d = $urandom_range(0, 17);
                dly.push_back(d); delay_q.push_back(d);
            end
            rw0 = c_rw[0]; addr0 = c_addr[0]; wdata0 = c_wdata[0];
            rw1 = c_rw[1]; addr1 = c_addr[1]; wdata1 = c_wdata[1];
            req0 = mask[0]; req1 = mask[1];
            foreach (order[k]) begin
                p = order[k]; d = dly[k];
                ok = (d != 0) && (d <= TIMEOUT);
                exp_en = ok ? d : TIMEOUT;
                if (ok && c_rw[p]) exp_rdata = shadow[c_addr[p][7:0]];
                if (ok && !c_rw[p]) shadow[c_addr[p][7:0]] = c_wdata[p];
                run_until_done(80);
                checks++; if (r_to !== 1'b0 || r_got0 !== (p == 0) || r_got1 !== (p == 1) || r_busy !== 1'b1) begin
                    failures++; $display("FAIL rnd%0d_port got to=%b d0=%b d1=%b busy=%b want port %0d",
                                         rnd, r_to, r_got0, r_got1, r_busy, p); end
                checks++; if (snap_owner !== p[0] || snap_rw !== c_rw[p] || snap_addr !== c_addr[p] ||
                              (!c_rw[p] && snap_wdata !== c_wdata[p])) begin
                    failures++; $display("FAIL rnd%0d_cmd got own=%b rw=%b addr=%h wd=%h want %0d/%b/%h/%h",
                                         rnd, snap_owner, snap_rw, snap_addr, snap_wdata, p, c_rw[p], c_addr[p], c_wdata[p]); end
                checks++; if ({r_err1, r_err0} !== (ok ? 2'b00 : ((p == 1) ? 2'b10 : 2'b01)) || r_en !== exp_en) begin
                    failures++; $display("FAIL rnd%0d_outcome got err=%b%b en=%0d want ok=%b en=%0d (delay %0d)",
                                         rnd, r_err1, r_err0, r_en, ok, exp_en, d); end
                checks++; if (r_rdata !== exp_rdata) begin
                    failures++; $display("FAIL rnd%0d_rdata got %h want %h", rnd, r_rdata, exp_rdata); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) env_mem[i] = '0;
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_timeout();
        test_reset_mid_busy();
        test_mfc_stuck();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
